// File: rtl/uart_txd_if.sv
// Host-side handshake and serial line bundle for uart_txd.
// master: byte source driving tx_data/tx_start.
// slave : the transmitter, driving tx_busy/tx_done/txd.
interface uart_txd_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_start;
  logic                 tx_busy;
  logic                 tx_done;
  logic                 txd;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done,
    input  txd
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done,
    output txd
  );
endinterface

// File: rtl/uart_txd.sv
// UART transmitter: one word per handshake, serialised as 8N1 (or 8E1).
// Optional even-parity bit is enabled by defining UART_TXD_PARITY_EN.
//
// state  | meaning
// -------+----------------------------------------------
// IDLE   | line high, waiting for tx_start
// START  | start bit, txd = 0
// DATA   | data bits, LSB first
// PARITY | even-parity bit (UART_TXD_PARITY_EN only)
// STOP   | stop bit, txd = 1
module uart_txd #(
  parameter int CLK_DIV   = 16,
  parameter int DATA_BITS = 8
) (
  input  logic       clk,
  input  logic       reset,
  uart_txd_if.slave  tx_if
);

  localparam int BW = $clog2(CLK_DIV);
  localparam int CW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

`ifdef UART_TXD_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state_q, state_d;
  logic [BW-1:0]        baud_q, baud_d;
  logic [CW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 txd_q, txd_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 bit_tick;
`ifdef UART_TXD_PARITY_EN
  logic                 parity_q, parity_d;
`endif

  assign bit_tick = (baud_q == BAUD_MAX);

  // State and datapath registers; reset forces an idle, high line at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TXD_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TXD_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Next-state: each bit-period state advances on bit_tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tx_if.tx_start) state_d = START;
      START:   if (bit_tick) state_d = DATA;
      DATA: begin
        if (bit_tick && (bit_q == LAST_BIT)) begin
`ifdef UART_TXD_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_TXD_PARITY_EN
      PARITY:  if (bit_tick) state_d = STOP;
`endif
      STOP:    if (bit_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered outputs; txd is set one edge ahead of each bit.
  always_comb begin
    baud_d  = bit_tick ? '0 : baud_q + BW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    txd_d   = txd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
`ifdef UART_TXD_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        txd_d  = 1'b1;
        if (tx_if.tx_start) begin
          shift_d = tx_if.tx_data;
          txd_d   = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TXD_PARITY_EN
          parity_d = ^tx_if.tx_data;
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          bit_d = '0;
          txd_d = shift_q[0];
        end
      end
      DATA: begin
        if (bit_tick) begin
          if (bit_q != LAST_BIT) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + CW'(1);
            txd_d   = shift_q[1];
          end else begin
`ifdef UART_TXD_PARITY_EN
            txd_d = parity_q;
`else
            txd_d = 1'b1;
`endif
          end
        end
      end
`ifdef UART_TXD_PARITY_EN
      PARITY: begin
        if (bit_tick) txd_d = 1'b1;
      end
`endif
      STOP: begin
        if (bit_tick) begin
          busy_d = 1'b0;
          done_d = 1'b1;
          txd_d  = 1'b1;
        end
      end
      default: begin
        baud_d = '0;
        busy_d = 1'b0;
        txd_d  = 1'b1;
      end
    endcase
  end

  assign tx_if.txd     = txd_q;
  assign tx_if.tx_busy = busy_q;
  assign tx_if.tx_done = done_q;

endmodule
